// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the handshaked memory stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    // width_src[1:0] is log2 of the access size in bytes; width_src[2] selects zero-extension
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;
    localparam int unsigned WIDTH_UNSIGNED_BIT = 2;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FULL  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    function automatic int unsigned off_width(int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

    // A doubleword access on a 32-bit datapath degrades to a word access.
    function automatic logic [1:0] eff_size(logic [1:0] sz, int unsigned xlen);
        if (xlen == 32 && sz == SZ_DWORD) return SZ_WORD;
        return sz;
    endfunction

endpackage

// File: rtl/load_align.sv
// Shifts a load response down to its byte lane and sign/zero-extends it to XLEN.
module load_align
    import mem_stage_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned OFF_W = off_width(XLEN)
) (
    input  logic [XLEN-1:0]  rsp_data,
    input  logic [OFF_W-1:0] off,
    input  logic [2:0]       width,
    output logic [XLEN-1:0]  result_c
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [1:0]      size;
    logic            sign;

    always_comb begin
        shifted = rsp_data >> {off, 3'b000};
        size    = eff_size(width[1:0], XLEN);
        mask    = '1;
        sign    = shifted[XLEN-1];
        case (size)
            SZ_BYTE: begin mask = XLEN'(8'hFF);         sign = shifted[7];  end
            SZ_HALF: begin mask = XLEN'(16'hFFFF);      sign = shifted[15]; end
            SZ_WORD: begin mask = XLEN'(32'hFFFF_FFFF); sign = shifted[31]; end
            default: begin mask = '1;                   sign = shifted[XLEN-1]; end
        endcase
        result_c = (shifted & mask) |
                   ((sign & ~width[WIDTH_UNSIGNED_BIT]) ? ~mask : '0);
    end

endmodule

// File: rtl/memory_stage_hs.sv
// One-entry memory pipeline stage with valid/ready execute, memory and writeback ports.
module memory_stage_hs
    import mem_stage_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned SB_W  = 64,
    localparam int unsigned BE_W  = XLEN / 8
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              flush_i,
    input  logic              valid_e_i,
    output logic              ready_e_o,
    input  logic [XLEN-1:0]   addr_e_i,
    input  logic [XLEN-1:0]   wdata_e_i,
    input  logic [XLEN-1:0]   result_e_i,
    input  logic [4:0]        rd_e_i,
    input  logic              reg_write_e_i,
    input  logic [1:0]        mem_op_e_i,
    input  logic [2:0]        width_src_e_i,
    input  logic [SB_W-1:0]   sideband_e_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rsp_valid_i,
    input  logic [XLEN-1:0]   mem_rsp_data_i,
    output logic              valid_m_o,
    input  logic              ready_w_i,
    output logic [XLEN-1:0]   result_m_o,
    output logic [4:0]        rd_m_o,
    output logic              forward_valid_m_o,
    output logic [SB_W-1:0]   sideband_m_o
);

    localparam int unsigned OFF_W = off_width(XLEN);
    localparam int unsigned BE2_W = 2 * BE_W;

    state_e            state, state_nxt, entry_state;
    logic [OFF_W-1:0]  off_q, off_in;
    logic [2:0]        width_q;
    logic              reg_write_q, we_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   result_q, addr_q, wdata_q, wdata_in, load_result_c;
    logic [BE_W-1:0]   be_q, be_in;
    logic [BE2_W-1:0]  be_base, be_wide;
    logic [1:0]        size_in;
    logic [SB_W-1:0]   sideband_q;
    logic              accept, req_fire, is_mem_in, occupied;

    assign ready_e_o = reset_n_i & ~flush_i &
                       ((state == ST_EMPTY) | ((state == ST_FULL) & ready_w_i));
    assign accept          = valid_e_i & ready_e_o;
    assign mem_req_valid_o = reset_n_i & ~flush_i & (state == ST_REQ);
    assign req_fire        = mem_req_valid_o & mem_req_ready_i;
    assign is_mem_in       = (mem_op_e_i == MEM_LOAD) | (mem_op_e_i == MEM_STORE);
    assign entry_state     = is_mem_in ? ST_REQ : ST_FULL;

    // Store byte enables and lane-replicated write data for the incoming entry
    always_comb begin
        size_in = eff_size(width_src_e_i[1:0], XLEN);
        off_in  = addr_e_i[OFF_W-1:0];
        case (size_in)
            SZ_BYTE: be_base = BE2_W'(1'b1);
            SZ_HALF: be_base = BE2_W'(2'b11);
            SZ_WORD: be_base = BE2_W'(4'hF);
            default: be_base = BE2_W'(8'hFF);
        endcase
        be_wide = be_base << off_in;
        be_in   = be_wide[BE_W-1:0];
        for (int unsigned i = 0; i < BE_W; i++) begin
            wdata_in[8*i +: 8] = wdata_e_i[8*(i & ((32'd1 << size_in) - 32'd1)) +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = entry_state;
            ST_REQ: begin
                if (flush_i)       state_nxt = ST_EMPTY;
                else if (req_fire) state_nxt = we_q ? ST_FULL : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush_i)              state_nxt = mem_rsp_valid_i ? ST_EMPTY : ST_DRAIN;
                else if (mem_rsp_valid_i) state_nxt = ST_FULL;
            end
            ST_DRAIN: if (mem_rsp_valid_i) state_nxt = ST_EMPTY;
            ST_FULL: begin
                if (flush_i)        state_nxt = ST_EMPTY;
                else if (ready_w_i) state_nxt = accept ? entry_state : ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state       <= ST_EMPTY;
            off_q       <= '0;
            width_q     <= '0;
            reg_write_q <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            result_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            sideband_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                off_q       <= off_in;
                width_q     <= width_src_e_i;
                reg_write_q <= reg_write_e_i;
                we_q        <= (mem_op_e_i == MEM_STORE);
                rd_q        <= rd_e_i;
                result_q    <= result_e_i;
                addr_q      <= {addr_e_i[XLEN-1:OFF_W], OFF_W'(0)};
                wdata_q     <= wdata_in;
                be_q        <= be_in;
                sideband_q  <= sideband_e_i;
            end else if (state == ST_WAIT && mem_rsp_valid_i && !flush_i) begin
                result_q <= load_result_c;
            end
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rsp_data (mem_rsp_data_i),
        .off      (off_q),
        .width    (width_q),
        .result_c (load_result_c)
    );

    assign occupied          = (state == ST_REQ) | (state == ST_WAIT) | (state == ST_FULL);
    assign mem_we_o          = we_q;
    assign mem_addr_o        = addr_q;
    assign mem_be_o          = be_q;
    assign mem_wdata_o       = wdata_q;
    assign valid_m_o         = (state == ST_FULL);
    assign forward_valid_m_o = (state == ST_FULL);
    assign result_m_o        = result_q;
    assign rd_m_o            = (occupied & reg_write_q) ? rd_q : 5'd0;
    assign sideband_m_o      = sideband_q;

endmodule
